dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side target for processor data accesses: accepts one load/store request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then performs the access on an internal word array with byte-lane write strobes.
- Returns data and status over a valid/ready response channel.
- Sits behind the core's data port as the multi-cycle replacement for the single-cycle data memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the array.
- WAIT_CYCLES, 2, wait states inserted between request accept and access; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables for stores; bit i selects wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access error flag qualified by resp_valid.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, wait counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, captured request cleared.
  - req_ready is forced 0 while reset is low.
  - Array contents are not reset and are preserved across reset.
- req_ready = reset high AND state == IDLE. Combinational from state; no combinational path from req_valid.
- FSM:
  - IDLE: on req_valid & req_ready at an edge, capture write, addr, wdata and wstrb, load counter = WAIT_CYCLES, go to WAIT.
  - WAIT: if counter != 0, decrement. If counter == 0, perform the access at this edge and go to RESP with resp_valid = 1.
  - RESP: hold resp_valid, resp_rdata and resp_err stable while resp_ready = 0. On resp_valid & resp_ready at an edge, go to IDLE and clear resp_valid.
- Latency:
  - Accept at edge E0 → resp_valid rises after edge E0+WAIT_CYCLES+1.
  - Minimum 2 cycles when WAIT_CYCLES = 0.
  - Earliest next accept is the edge after the response handshake.
- Word index = req_addr[31:2]. Out of range when index >= DEPTH.
- Store (in range, no error):
  - Lanes with wstrb = 1 are updated; other lanes are unchanged.
  - wstrb = 0000 is a legal no-op with resp_err = 0.
  - resp_rdata = 0.
- Load (in range, no error): resp_rdata = full stored word, read at the access edge. This reflects all earlier completed stores.
- Out-of-range access: store suppressed, resp_rdata = 0, resp_err = 1.
- Request inputs are ignored outside IDLE. The requester must hold req_* stable until accepted.
- Reset asserted mid-WAIT or mid-RESP: the transaction is abandoned; no array write occurs unless the access edge already completed.

Optional Feature:
- Macro DMEM_MISALIGN_ERR_EN.
- Defined: req_addr[1:0] != 00 is an error. Store suppressed, resp_rdata = 0, resp_err = 1, same timing as a normal access.
- Undefined: req_addr[1:0] is ignored; the access goes to the word at req_addr[31:2] with no error.

Test Plan:
- WAIT_CYCLES = 2: store 0xDEADBEEF to 0x10 with wstrb 1111, then load 0x10 → rdata 0xDEADBEEF, err 0. Each resp_valid rises exactly 3 cycles after accept.
- Store 0x000000AA to 0x10 with wstrb 0001, then load 0x10 → 0xDEADBEAA. Then wstrb 0000 store → word unchanged, err 0.
- resp_ready held low 5 cycles during a load response → resp_valid/rdata/err held stable and req_ready stays 0. Completion occurs only on the handshake edge.
- Load from 0x100 (index 64, DEPTH 64) → rdata 0, err 1. Store to 0x100 → err 1 and array unchanged, confirmed by reading index 0 and index 63.
- Load 0x12 with DMEM_MISALIGN_ERR_EN defined → err 1, rdata 0. Without the macro → err 0, returns the word at 0x10.
- Assert reset low mid-WAIT of a store to 0x20 → resp_valid 0 and req_ready 0 immediately. After release, req_ready = 1 and a load of 0x20 returns the prior contents; WAIT_CYCLES = 0 load completes in 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with programmable wait states.
// Define DMEM_MISALIGN_ERR_EN to flag non-word-aligned accesses as errors.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  req_t          cap;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          access;
  logic          done;
  logic          in_range;
  logic          misalign;
  logic          err;
  logic          we;
  logic [AW-1:0] idx;

  assign accept   = req_valid && req_ready;
  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign done     = resp_valid && resp_ready;
  assign in_range = cap.addr[31:2] < 30'(DEPTH);
  assign idx      = cap.addr[AW+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = |cap.addr[1:0];
`else
  // Byte offset is ignored; the word at addr[31:2] is accessed.
  logic unused_lo;
  assign unused_lo = ^cap.addr[1:0];
  assign misalign  = 1'b0;
`endif

  assign err = !in_range || misalign;
  assign we  = access && cap.write && !err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: if (access) state_nx = RESP;
      RESP: if (done)   state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = reset && (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      cap        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap <= '{write: req_write, addr: req_addr,
                 wdata: req_wdata, wstrb: req_wstrb};
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err   <= err;
        resp_rdata <= (!cap.write && !err) ? mem[idx] : '0;
      end
    end
  end

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (cap.wstrb[i]) mem[idx][8*i +: 8] <= cap.wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder.
// Runs a WAIT_CYCLES=2 instance for most vectors and a WAIT_CYCLES=0 one.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_ready = 1'b0;
  int          sel = 2;

  always #5 clk = ~clk;

  logic        v0, v2, rr0, rr2, rv0, rv2, re0, re2, rp0, rp2;
  logic [31:0] rd0, rd2;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  assign v0  = req_valid && (sel == 0);
  assign v2  = req_valid && (sel == 2);
  assign rp0 = resp_ready && (sel == 0);
  assign rp2 = resp_ready && (sel == 2);
  assign req_ready  = (sel == 0) ? rr0 : rr2;
  assign resp_valid = (sel == 0) ? rv0 : rv2;
  assign resp_err   = (sel == 0) ? re0 : re2;
  assign resp_rdata = (sel == 0) ? rd0 : rd2;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(v2), .req_ready(rr2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(rv2), .resp_ready(rp2),
    .resp_rdata(rd2), .resp_err(re2)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_ready(rr0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(rv0), .resp_ready(rp0),
    .resp_rdata(rd0), .resp_err(re0)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic txn(input string nm, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input int hold, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    logic [31:0] rd;
    logic e;
    logic stable;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, ":lat"}, 32'(lat), 32'(exp_lat));
    rd = resp_rdata;
    e  = resp_err;
    chk({nm, ":rdata"}, rd, exp_rd);
    chk({nm, ":err"}, 32'(e), 32'(exp_err));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!resp_valid || resp_rdata !== rd || resp_err !== e || req_ready)
        stable = 1'b0;
    end
    if (hold > 0) chk({nm, ":hold"}, 32'(stable), 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({nm, ":done"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          hold;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 0, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0};
    vt[4]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0};
    vt[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0};
    vt[6]  = '{1'b1, 32'h0,   32'h11223344, 4'hF, 0, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 32'hFC,  32'h55667788, 4'hF, 0, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 32'h100, 32'h0,        4'h0, 0, 32'h0, 1'b1};
    vt[9]  = '{1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b1};
    vt[10] = '{1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h11223344, 1'b0};
    vt[11] = '{1'b0, 32'hFC,  32'h0,        4'h0, 0, 32'h55667788, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
    vt[12] = '{1'b0, 32'h12,  32'h0,        4'h0, 0, 32'h0, 1'b1};
    vt[13] = '{1'b1, 32'h12,  32'h00FF0000, 4'h4, 0, 32'h0, 1'b1};
    vt[14] = '{1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0};
`else
    vt[12] = '{1'b0, 32'h12,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0};
    vt[13] = '{1'b1, 32'h12,  32'h00FF0000, 4'h4, 0, 32'h0, 1'b0};
    vt[14] = '{1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEFFBEAA, 1'b0};
`endif
    vt[15] = '{1'b1, 32'h20,  32'h0A0B0C0D, 4'hF, 0, 32'h0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rr2), 32'd0);
    chk("rst_valid", 32'(rv2), 32'd0);
    chk("rst_rdata", rd2, 32'd0);
    chk("rst_err", 32'(re2), 32'd0);
    chk("rst_ready0", {30'd0, rr0, rv0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(rr2), 32'd1);

    sel = 2;
    for (int i = 0; i < 16; i++) begin
      txn($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].s,
          vt[i].hold, 3, vt[i].rd, vt[i].e);
    end

    // Abandon a store to 0x20 mid-wait; prior contents must survive.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h99999999;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_rel", 32'(req_ready), 32'd1);
    txn("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, 3, 32'h0A0B0C0D, 1'b0);

    sel = 0;
    txn("w0_st", 1'b1, 32'h20, 32'h13579BDF, 4'hF, 0, 1, 32'h0, 1'b0);
    txn("w0_ld", 1'b0, 32'h20, 32'h0, 4'h0, 2, 1, 32'h13579BDF, 1'b0);
    txn("w0_oor", 1'b0, 32'h104, 32'h0, 4'h0, 0, 1, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
